// File: rtl/des_sbox_layer.sv
// DES S-box substitution layer (S1..S8), 48-bit key-mixed half-block in, 32-bit pre-P result out.
// LANES lookups per cycle; result valid 8/LANES cycles after accept; holds in DONE until o_ready.
module des_sbox_layer #(
  parameter int unsigned LANES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [47:0] i_data,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] o_data,
  output logic        o_busy
);

  localparam int unsigned STEPS = 8 / ((LANES == 0) ? 1 : LANES);
  localparam int unsigned SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
      $error("des_sbox_layer: LANES must be 1, 2, 4 or 8");
    end
  endgenerate

  // Each table is 64 nibbles in reading order: entry row*16+col sits at the top of the vector.
  localparam logic [255:0] SBOX_TBL [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] b);
    logic [5:0]   idx;
    logic [255:0] shifted;
    idx     = {b[5], b[0], b[4:1]};
    shifted = SBOX_TBL[box] >> {~idx, 2'b00};
    return shifted[3:0];
  endfunction

  state_t             state_q, state_d;
  logic [7:0][5:0]    data_q, data_d;
  logic [7:0][3:0]    result_q, result_d;
  logic [SW-1:0]      step_q, step_d;
  logic [2:0]         box;

  assign i_ready = rst_n && ((state_q == IDLE) || ((state_q == DONE) && o_ready));
  assign o_valid = (state_q == DONE);
  assign o_data  = result_q;
  assign o_busy  = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    result_d = result_q;
    step_d   = step_q;
    box      = '0;
    case (state_q)
      IDLE: begin
        if (i_valid && i_ready) begin
          data_d  = i_data;
          step_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // S1 lives in the top element of both packed arrays, so box j maps to element ~j.
        for (int k = 0; k < int'(LANES); k++) begin
          box           = 3'(int'(step_q) * int'(LANES) + k);
          result_d[~box] = sbox_lookup(box, data_q[~box]);
        end
        if (step_q == LAST) begin
          state_d = DONE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        if (o_ready) begin
          if (i_valid) begin
            data_d  = i_data;
            step_d  = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      result_q <= '0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      result_q <= result_d;
      step_q   <= step_d;
    end
  end

endmodule

// File: tb/tb_des_sbox_layer.sv
// Bench for des_sbox_layer: one instance per legal LANES value, directed vectors plus a random soak.
module tb_des_sbox_layer;

  logic        clk;
  logic        rst_n;
  logic        in_vld  [4];
  logic        in_rdy  [4];
  logic [47:0] in_dat  [4];
  logic        out_vld [4];
  logic        out_rdy [4];
  logic [31:0] out_dat [4];
  logic        busy    [4];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [47:0] din;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs [10];

  // Reference S-boxes, index row*16+col.
  int sb_tab [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  des_sbox_layer #(.LANES(1)) u_l1 (.clk(clk), .rst_n(rst_n), .i_valid(in_vld[0]), .i_ready(in_rdy[0]),
    .i_data(in_dat[0]), .o_valid(out_vld[0]), .o_ready(out_rdy[0]), .o_data(out_dat[0]), .o_busy(busy[0]));
  des_sbox_layer #(.LANES(2)) u_l2 (.clk(clk), .rst_n(rst_n), .i_valid(in_vld[1]), .i_ready(in_rdy[1]),
    .i_data(in_dat[1]), .o_valid(out_vld[1]), .o_ready(out_rdy[1]), .o_data(out_dat[1]), .o_busy(busy[1]));
  des_sbox_layer #(.LANES(4)) u_l4 (.clk(clk), .rst_n(rst_n), .i_valid(in_vld[2]), .i_ready(in_rdy[2]),
    .i_data(in_dat[2]), .o_valid(out_vld[2]), .o_ready(out_rdy[2]), .o_data(out_dat[2]), .o_busy(busy[2]));
  des_sbox_layer #(.LANES(8)) u_l8 (.clk(clk), .rst_n(rst_n), .i_valid(in_vld[3]), .i_ready(in_rdy[3]),
    .i_data(in_dat[3]), .o_valid(out_vld[3]), .o_ready(out_rdy[3]), .o_data(out_dat[3]), .o_busy(busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] model(input logic [47:0] d);
    logic [31:0] r;
    logic [5:0]  b;
    r = '0;
    for (int s = 0; s < 8; s++) begin
      b = 6'(d >> (6 * (7 - s)));
      r = (r << 4) | 32'(sb_tab[s][{b[5], b[0], b[4:1]}]);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single block with o_ready held high: checks accept, exact latency, result and return to IDLE.
  task automatic apply_vec(input int li, input logic [47:0] din, input logic [31:0] exp, input string tag);
    int    n;
    int    e;
    int    steps;
    string nm;
    steps = 8 >> li;
    nm    = $sformatf("%s_L%0d", tag, 1 << li);
    in_vld[li]  = 1'b1;
    in_dat[li]  = din;
    out_rdy[li] = 1'b1;
    #1;
    n = 0;
    while (in_rdy[li] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_acc"}, 64'(in_rdy[li]), 64'd1);
    tick();
    in_vld[li] = 1'b0;
    in_dat[li] = ~din;
    e = 0;
    while (e < steps) begin
      chk({nm, "_early_vld"}, 64'(out_vld[li]), 64'd0);
      chk({nm, "_busy"}, 64'(busy[li]), 64'd1);
      tick();
      e++;
    end
    chk({nm, "_vld"}, 64'(out_vld[li]), 64'd1);
    chk({nm, "_dat"}, 64'(out_dat[li]), 64'(exp));
    tick();
    chk({nm, "_idle_vld"}, 64'(out_vld[li]), 64'd0);
    chk({nm, "_idle_busy"}, 64'(busy[li]), 64'd0);
  endtask

  task automatic backpressure(input int li);
    int    e;
    int    steps;
    string nm;
    steps = 8 >> li;
    nm    = $sformatf("bp_L%0d", 1 << li);
    in_vld[li]  = 1'b1;
    in_dat[li]  = 48'h820820820820;
    out_rdy[li] = 1'b0;
    #1;
    chk({nm, "_acc"}, 64'(in_rdy[li]), 64'd1);
    tick();
    in_dat[li] = 48'hFFFFFFFFFFFF;
    e = 0;
    while (out_vld[li] !== 1'b1 && e < steps + 4) begin
      tick();
      e++;
    end
    chk({nm, "_lat"}, 64'(e), 64'(steps));
    for (int c = 0; c < 5; c++) begin
      chk({nm, "_hold_vld"}, 64'(out_vld[li]), 64'd1);
      chk({nm, "_hold_dat"}, 64'(out_dat[li]), 64'h40DA4917);
      chk({nm, "_hold_rdy"}, 64'(in_rdy[li]), 64'd0);
      tick();
    end
    out_rdy[li] = 1'b1;
    #1;
    chk({nm, "_rdy_comb"}, 64'(in_rdy[li]), 64'd1);
    tick();
    in_vld[li] = 1'b0;
    chk({nm, "_after_dual"}, 64'(out_vld[li]), 64'd0);
    chk({nm, "_busy_dual"}, 64'(busy[li]), 64'd1);
    e = 0;
    while (out_vld[li] !== 1'b1 && e < steps + 4) begin
      tick();
      e++;
    end
    chk({nm, "_lat2"}, 64'(e), 64'(steps));
    chk({nm, "_dat2"}, 64'(out_dat[li]), 64'hD9CE3DCB);
    tick();
    chk({nm, "_idle"}, 64'(busy[li]), 64'd0);
  endtask

  task automatic soak(input int li, input int nblk);
    logic [31:0] expq [$];
    logic [63:0] r;
    logic [31:0] hold_dat;
    logic        hold_pend;
    int          sent;
    int          got;
    int          cyc;
    string       nm;
    nm        = $sformatf("soak_L%0d", 1 << li);
    sent      = 0;
    got       = 0;
    cyc       = 0;
    hold_pend = 1'b0;
    hold_dat  = '0;
    while (got < nblk && cyc < 40000) begin
      r           = {$urandom, $urandom};
      in_vld[li]  = (sent < nblk) && ($urandom_range(0, 1) == 1);
      in_dat[li]  = r[47:0];
      out_rdy[li] = ($urandom_range(0, 3) != 0);
      #1;
      if (hold_pend) begin
        chk({nm, "_stable_vld"}, 64'(out_vld[li]), 64'd1);
        chk({nm, "_stable_dat"}, 64'(out_dat[li]), 64'(hold_dat));
      end
      if (out_vld[li] && out_rdy[li]) begin
        chk({nm, "_nodup"}, 64'(expq.size() > 0), 64'd1);
        if (expq.size() > 0) chk({nm, "_dat"}, 64'(out_dat[li]), 64'(expq.pop_front()));
        got++;
      end
      if (in_vld[li] && in_rdy[li]) begin
        expq.push_back(model(in_dat[li]));
        sent++;
      end
      hold_pend = out_vld[li] && !out_rdy[li];
      hold_dat  = out_dat[li];
      tick();
      cyc++;
    end
    in_vld[li]  = 1'b0;
    out_rdy[li] = 1'b1;
    chk({nm, "_count"}, 64'(got), 64'(nblk));
    chk({nm, "_left"}, 64'(expq.size()), 64'd0);
    repeat (12) tick();
    chk({nm, "_no_extra"}, 64'(out_vld[li]), 64'd0);
  endtask

  initial begin
    int n_vld;
    vecs[0] = '{48'h000000000000, 32'hEFA72C4D};
    vecs[1] = '{48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
    vecs[2] = '{48'h040000000000, 32'h0FA72C4D};
    vecs[3] = '{48'h001000000000, 32'hE3A72C4D};
    vecs[4] = '{48'h000040000000, 32'hEFD72C4D};
    vecs[5] = '{48'h000001000000, 32'hEFAD2C4D};
    vecs[6] = '{48'h000000040000, 32'hEFA7EC4D};
    vecs[7] = '{48'h000000001000, 32'hEFA72A4D};
    vecs[8] = '{48'h000000000040, 32'hEFA72CDD};
    vecs[9] = '{48'h000000000001, 32'hEFA72C41};

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_vld[i]  = 1'b1;
      in_dat[i]  = 48'h123456789ABC;
      out_rdy[i] = 1'b1;
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_rdy_L%0d", 1 << i), 64'(in_rdy[i]), 64'd0);
      chk($sformatf("rst_vld_L%0d", 1 << i), 64'(out_vld[i]), 64'd0);
      chk($sformatf("rst_busy_L%0d", 1 << i), 64'(busy[i]), 64'd0);
      chk($sformatf("rst_dat_L%0d", 1 << i), 64'(out_dat[i]), 64'd0);
      in_vld[i] = 1'b0;
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("idle_rdy_L%0d", 1 << i), 64'(in_rdy[i]), 64'd1);

    for (int v = 0; v < 10; v++)
      for (int i = 0; i < 4; i++)
        apply_vec(i, vecs[v].din, vecs[v].dout, $sformatf("vec%0d", v));
    apply_vec(2, 48'h820820820820, 32'h40DA4917, "row2");
    apply_vec(1, 48'h79E79E79E79E, 32'h7A8F9B17, "col15");

    for (int i = 0; i < 4; i++) backpressure(i);

    // Reset while the LANES=1 instance is at step 3.
    in_vld[0]  = 1'b1;
    in_dat[0]  = 48'hFFFFFFFFFFFF;
    out_rdy[0] = 1'b1;
    #1;
    chk("mid_rst_acc", 64'(in_rdy[0]), 64'd1);
    tick();
    in_vld[0] = 1'b0;
    n_vld = 0;
    repeat (3) begin
      tick();
      if (out_vld[0]) n_vld++;
    end
    rst_n = 1'b0;
    tick();
    chk("mid_rst_vld", 64'(out_vld[0]), 64'd0);
    chk("mid_rst_busy", 64'(busy[0]), 64'd0);
    chk("mid_rst_dat", 64'(out_dat[0]), 64'd0);
    chk("mid_rst_rdy", 64'(in_rdy[0]), 64'd0);
    rst_n = 1'b1;
    repeat (12) begin
      tick();
      if (out_vld[0]) n_vld++;
    end
    chk("mid_rst_no_result", 64'(n_vld), 64'd0);
    apply_vec(0, 48'h000000000000, 32'hEFA72C4D, "post_rst");

    fork
      soak(0, 1200);
      soak(1, 1200);
      soak(2, 1200);
      soak(3, 1200);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
